// File: rtl/moore_seq_detector_if.sv
// Serial detector bus: sample enable, data bit and counter clear toward the detector;
// match flag, matched-prefix length and match count back from it.
// LEN and CNT_W must match the detector instance.
interface moore_seq_detector_if #(
  parameter int unsigned LEN   = 4,
  parameter int unsigned CNT_W = 8
);

  localparam int unsigned SW = $clog2(LEN + 1);

  logic             en;
  logic             W;
  logic             clr;
  logic             Z;
  logic [SW-1:0]    state;
  logic [CNT_W-1:0] match_cnt;

  // Stream source / observer side
  modport master (
    output en,
    output W,
    output clr,
    input  Z,
    input  state,
    input  match_cnt
  );

  // Detector side
  modport slave (
    input  en,
    input  W,
    input  clr,
    output Z,
    output state,
    output match_cnt
  );

endinterface

// File: rtl/moore_seq_detector.sv
// Moore serial pattern detector for an arbitrary LEN-bit PATTERN (first bit on W is
// PATTERN[LEN-1]). State k = length of the longest pattern prefix that is a suffix of
// the consumed stream. Z, state and match_cnt are all registered.
// Optional build macro: SEQDET_OVERLAP_EN -- when defined, a completed match keeps its
// longest proper prefix-suffix so overlapping occurrences are counted; otherwise
// matching restarts from scratch after every hit.
module moore_seq_detector #(
  parameter int unsigned    LEN     = 4,
  parameter logic [LEN-1:0] PATTERN = 4'b1011,
  parameter int unsigned    CNT_W   = 8
) (
  input logic                 clk,
  input logic                 reset_n,
  moore_seq_detector_if.slave bus
);

  localparam int unsigned SW = $clog2(LEN + 1);

  typedef logic [SW-1:0] state_t;

  localparam state_t           StIdle = '0;
  localparam state_t           StFull = state_t'(LEN);
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  if (LEN < 2 || LEN > 16) begin : gen_len_check
    $error("moore_seq_detector: LEN must lie in 2..16");
  end

  // Bit i of the pattern in arrival order (i = 0 is the first bit expected).
  function automatic logic pbit(int unsigned i);
    return PATTERN[LEN-1-i];
  endfunction

  // Longest j <= min(k+1, LEN) such that the first j pattern bits equal the last j bits
  // of (first k pattern bits followed by w). Only called with constant arguments.
  function automatic int unsigned longest_match(int unsigned k, logic w);
    int unsigned best;
    logic        ok;
    best = 0;
    for (int unsigned j = 1; j <= LEN; j++) begin
      if (j <= k + 1) begin
        ok = (pbit(j - 1) == w);
        for (int unsigned i = 0; i + 1 < j; i++) begin
          if (pbit(i) != pbit(k + 1 - j + i)) begin
            ok = 1'b0;
          end
        end
        if (ok) begin
          best = j;
        end
      end
    end
    return best;
  endfunction

`ifdef SEQDET_OVERLAP_EN
  // Longest proper prefix of the pattern that is also a suffix of it.
  function automatic int unsigned border_len();
    int unsigned best;
    logic        ok;
    best = 0;
    for (int unsigned b = 1; b < LEN; b++) begin
      ok = 1'b1;
      for (int unsigned i = 0; i < b; i++) begin
        if (pbit(i) != pbit(LEN - b + i)) begin
          ok = 1'b0;
        end
      end
      if (ok) begin
        best = b;
      end
    end
    return best;
  endfunction

  // After a hit the detector behaves as if only the border has been matched.
  localparam int unsigned ReentryFrom = border_len();
`else
  // After a hit nothing of the completed match is reused.
  localparam int unsigned ReentryFrom = 0;
`endif

  // Transition table, fully resolved at elaboration: next_tbl[state][W].
  state_t next_tbl [LEN+1][2];

  for (genvar k = 0; k <= LEN; k++) begin : gen_state
    for (genvar b = 0; b < 2; b++) begin : gen_bit
      localparam int unsigned From = (k == LEN) ? ReentryFrom : k;
      assign next_tbl[k][b] = state_t'(longest_match(From, (b != 0)));
    end
  end

  state_t           state_q, state_d;
  logic             z_q, z_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             enter_full;

  // Next state: consume W only when enabled; unreachable encodings fall back to idle.
  always_comb begin
    state_d = state_q;
    if (bus.en) begin
      if (state_q > StFull) begin
        state_d = StIdle;
      end else begin
        state_d = next_tbl[state_q][bus.W];
      end
    end
  end

  // Match flag and saturating counter; a clear on a hitting edge leaves exactly one count.
  always_comb begin
    enter_full = bus.en && (state_d == StFull);
    z_d        = (state_d == StFull);
    cnt_d      = cnt_q;
    if (bus.clr) begin
      cnt_d = enter_full ? CNT_W'(1) : '0;
    end else if (enter_full && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // FSM and registered outputs; asynchronous reset discards any partial match.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      z_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      z_q     <= z_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.state     = state_q;
  assign bus.Z         = z_q;
  assign bus.match_cnt = cnt_q;

endmodule
